// File: rtl/battleship_pkg.sv
// ============================================================================
// Module  : battleship_pkg
// Purpose : Shared types and constants for the battleship placing phase:
//           placement FSM states, ship orientation codes, the fleet table
//           and the cell codes shared with cell_io.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package battleship_pkg;

   // Number of entries in the fleet table
   localparam int MAX_SHIPS = 5;

   // Ship orientation
   localparam logic DIR_H = 1'b0;
   localparam logic DIR_V = 1'b1;

   // Ship lengths in placement order
   localparam logic [3:0] FLEET [MAX_SHIPS] = '{4'd5, 4'd4, 4'd3, 4'd3, 4'd2};

   // Cell memory codes, shared with cell_io
   localparam logic [1:0] CELL_EMPTY   = 2'd0;
   localparam logic [1:0] CELL_PREVIEW = 2'd1;
   localparam logic [1:0] CELL_SHIP    = 2'd2;
   localparam logic [1:0] CELL_BLOCKED = 2'd3;

   // Placement sequencer states
   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_ARMED    = 3'd1,
      ST_WRITE    = 3'd2,
      ST_WAIT_ACK = 3'd3,
      ST_NEXT     = 3'd4,
      ST_DONE     = 3'd5
   } place_state_t;

   // Length of fleet entry idx; indices past the table read as zero
   function automatic logic [3:0] fleet_dim(input logic [2:0] idx);
      logic [3:0] dim;
      dim = 4'd0;
      for (int i = 0; i < MAX_SHIPS; i++) begin
         if (idx == 3'(i)) dim = FLEET[i];
      end
      return dim;
   endfunction

endpackage : battleship_pkg

`default_nettype wire

// File: rtl/button_edge.sv
// ============================================================================
// Module  : button_edge
// Purpose : Raw mouse button level to one-cycle rising-edge pulse.
//           Two-flop synchroniser, optional debounce filter, registered
//           edge detector. Optional feature macro: CLICK_DEBOUNCE_EN.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module button_edge
`ifdef CLICK_DEBOUNCE_EN
#(
   parameter int DEBOUNCE_CYCLES = 16
)
`endif
(
   input  logic clk_in,
   input  logic rst,
   input  logic raw,
   output logic rise
);

   logic sync1;
   logic sync2;
   logic level;
   logic level_q;

   // Two-flop synchroniser for the asynchronous button level
   always_ff @(posedge clk_in) begin
      if (rst) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
      end
   end

`ifdef CLICK_DEBOUNCE_EN
   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

   logic [CNT_W-1:0] stable_cnt;
   logic             filt;

   // Filtered level follows the synchronised level only after
   // DEBOUNCE_CYCLES consecutive samples that disagree with it
   always_ff @(posedge clk_in) begin
      if (rst) begin
         stable_cnt <= '0;
         filt       <= 1'b0;
      end else if (sync2 == filt) begin
         stable_cnt <= '0;
      end else if (stable_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
         filt       <= sync2;
         stable_cnt <= '0;
      end else begin
         stable_cnt <= stable_cnt + 1'b1;
      end
   end

   assign level = filt;
`else
   assign level = sync2;
`endif

   // Registered rising-edge pulse, one cycle wide
   always_ff @(posedge clk_in) begin
      if (rst) begin
         level_q <= 1'b0;
         rise    <= 1'b0;
      end else begin
         level_q <= level;
         rise    <= level & ~level_q;
      end
   end

endmodule : button_edge

`default_nettype wire

// File: rtl/fleet_placement_ctrl.sv
// ============================================================================
// Module  : fleet_placement_ctrl
// Purpose : Player placing-phase sequencer upstream of cell_io. Turns mouse
//           clicks into a one-cycle write-enable plus orientation, walks the
//           fleet table and advances on cell_io's ship_placed acknowledge.
//           Optional feature macro: CLICK_DEBOUNCE_EN (button debounce).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module fleet_placement_ctrl
   import battleship_pkg::*;
#(
   parameter int NUM_SHIPS       = 5,
   parameter int ACK_WINDOW      = 2,
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic       clk_in,
   input  logic       rst,
   input  logic       start,
   input  logic       left_click,
   input  logic       right_click,
   input  logic       ship_placed,
   output logic       we,
   output logic       direction,
   output logic [3:0] dimension,
   output logic [2:0] ship_idx,
   output logic       rejected,
   output logic       placing_done
);

   localparam int         ACK_W    = (ACK_WINDOW > 1) ? $clog2(ACK_WINDOW) : 1;
   localparam logic [2:0] LAST_IDX = 3'(NUM_SHIPS - 1);

   place_state_t     state;
   logic [ACK_W-1:0] ack_cnt;
   logic [2:0]       next_idx;
   logic             left_edge;
   logic             right_edge;

   button_edge
`ifdef CLICK_DEBOUNCE_EN
      #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES))
`endif
   u_left_btn (
      .clk_in (clk_in),
      .rst    (rst),
      .raw    (left_click),
      .rise   (left_edge)
   );

   button_edge
`ifdef CLICK_DEBOUNCE_EN
      #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES))
`endif
   u_right_btn (
      .clk_in (clk_in),
      .rst    (rst),
      .raw    (right_click),
      .rise   (right_edge)
   );

   assign next_idx = ship_idx + 3'd1;

   // Placement sequencer; all outputs are registered here
   always_ff @(posedge clk_in) begin
      if (rst) begin
         state        <= ST_IDLE;
         we           <= 1'b0;
         direction    <= DIR_H;
         dimension    <= fleet_dim(3'd0);
         ship_idx     <= 3'd0;
         rejected     <= 1'b0;
         placing_done <= 1'b0;
         ack_cnt      <= '0;
      end else begin
         we       <= 1'b0;
         rejected <= 1'b0;
         if (!start && state != ST_DONE) begin
            // Pause: progress is kept so placement resumes on the same ship
            state <= ST_IDLE;
         end else begin
            case (state)
               ST_IDLE: begin
                  state <= ST_ARMED;
               end
               ST_ARMED: begin
                  // Rotation lands on the same edge as the write launch,
                  // so a simultaneous click writes with the new direction
                  if (right_edge) direction <= ~direction;
                  if (left_edge) begin
                     state <= ST_WRITE;
                     we    <= 1'b1;
                  end
               end
               ST_WRITE: begin
                  ack_cnt <= '0;
                  state   <= ship_placed ? ST_NEXT : ST_WAIT_ACK;
               end
               ST_WAIT_ACK: begin
                  if (ship_placed) begin
                     state <= ST_NEXT;
                  end else if (ack_cnt == ACK_W'(ACK_WINDOW - 1)) begin
                     rejected <= 1'b1;
                     state    <= ST_ARMED;
                  end else begin
                     ack_cnt <= ack_cnt + 1'b1;
                  end
               end
               ST_NEXT: begin
                  if (ship_idx == LAST_IDX) begin
                     state        <= ST_DONE;
                     placing_done <= 1'b1;
                  end else begin
                     ship_idx  <= next_idx;
                     dimension <= fleet_dim(next_idx);
                     state     <= ST_ARMED;
                  end
               end
               ST_DONE: begin
                  placing_done <= 1'b1;
               end
               default: begin
                  state <= ST_IDLE;
               end
            endcase
         end
      end
   end

endmodule : fleet_placement_ctrl

`default_nettype wire
